// File: rtl/fg_pkg.sv
// Shared definitions for the F/G sequence monitor: FSM states, violation codes
// and the length of a legal F, G, gap transaction.
package fg_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        S_F    = 2'd1,
        S_G    = 2'd2,
        RESYNC = 2'd3
    } fg_state_t;

    typedef enum logic [2:0] {
        ERR_NONE        = 3'd0,
        ERR_G_WITHOUT_F = 3'd1,
        ERR_F_LONG      = 3'd2,
        ERR_G_MISSING   = 3'd3,
        ERR_G_LONG      = 3'd4,
        ERR_NO_GAP      = 3'd5,
        ERR_BOTH_HIGH   = 3'd6,
        ERR_RESERVED    = 3'd7
    } fg_err_t;

    localparam int unsigned SEQ_LEN = 3;

endpackage

// File: rtl/fg_event_counter.sv
// Event counter with synchronous clear (priority over increment); the count
// either wraps or saturates at all-ones depending on SAT.
module fg_event_counter #(
    parameter int unsigned W   = 8,
    parameter bit          SAT = 1'b0
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_inc,
    input  logic         i_clr,
    output logic [W-1:0] o_cnt
);

    logic [W-1:0] r_cnt;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_inc) begin
            if (!(SAT && (r_cnt == '1))) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign o_cnt = r_cnt;

endmodule

// File: rtl/fg_seq_monitor.sv
// Receive-side protocol checker for the F/G pulse pair: counts good
// transactions and violations, logs the first violation code, resynchronises.
module fg_seq_monitor
    import fg_pkg::*;
#(
    parameter int unsigned CNT_W = 8,
    parameter int unsigned ERR_W = 4
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             F,
    input  logic             G,
    input  logic             Clear,
    output logic             Done,
    output logic             Busy,
    output logic             Err,
    output logic [2:0]       ErrCode,
    output logic [CNT_W-1:0] TxnCount,
    output logic [ERR_W-1:0] ErrCount
);

    fg_state_t r_state;
    fg_state_t w_next;
    fg_err_t   w_code;
    fg_err_t   r_code;
    logic      w_err;
    logic      w_done;
    logic      r_done;
    logic      r_err;

    always_ff @(posedge Clock) begin
        if (!Reset) begin
            r_state <= IDLE;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
            r_code  <= ERR_NONE;
        end else begin
            r_state <= w_next;
            r_done  <= w_done;
            if (Clear) begin
                r_err  <= 1'b0;
                r_code <= ERR_NONE;
            end else if (w_err) begin
                r_err <= 1'b1;
                // First violation since reset/Clear wins
                if (!r_err) begin
                    r_code <= w_code;
                end
            end
        end
    end

    always_comb begin
        w_next = r_state;
        w_err  = 1'b0;
        w_code = ERR_NONE;
        w_done = 1'b0;
        unique case (r_state)
            IDLE: begin
                case ({F, G})
                    2'b10:   w_next = S_F;
                    2'b01:   begin w_err = 1'b1; w_code = ERR_G_WITHOUT_F; end
                    2'b11:   begin w_err = 1'b1; w_code = ERR_BOTH_HIGH;   end
                    default: w_next = IDLE;
                endcase
            end
            S_F: begin
                case ({F, G})
                    2'b01:   w_next = S_G;
                    2'b10:   begin w_err = 1'b1; w_code = ERR_F_LONG;    end
                    2'b11:   begin w_err = 1'b1; w_code = ERR_BOTH_HIGH; end
                    default: begin w_err = 1'b1; w_code = ERR_G_MISSING; end
                endcase
            end
            S_G: begin
                case ({F, G})
                    2'b00:   begin w_next = IDLE; w_done = 1'b1; end
                    2'b01:   begin w_err = 1'b1; w_code = ERR_G_LONG;    end
                    2'b10:   begin w_err = 1'b1; w_code = ERR_NO_GAP;    end
                    default: begin w_err = 1'b1; w_code = ERR_BOTH_HIGH; end
                endcase
            end
            RESYNC: begin
                if ({F, G} == 2'b00) begin
                    w_next = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
        if (w_err) begin
            w_next = RESYNC;
        end
    end

    fg_event_counter #(.W(CNT_W), .SAT(1'b0)) u_txn_cnt (
        .i_clk   (Clock),
        .i_rst_n (Reset),
        .i_inc   (w_done),
        .i_clr   (Clear),
        .o_cnt   (TxnCount)
    );

    fg_event_counter #(.W(ERR_W), .SAT(1'b1)) u_err_cnt (
        .i_clk   (Clock),
        .i_rst_n (Reset),
        .i_inc   (w_err),
        .i_clr   (Clear),
        .o_cnt   (ErrCount)
    );

    assign Done    = r_done;
    assign Err     = r_err;
    assign ErrCode = r_code;
    assign Busy    = (r_state == S_F) || (r_state == S_G);

endmodule

// File: tb/tb_fg_seq_monitor.sv
// Directed bench for fg_seq_monitor: a default-width instance and a narrow
// (2-bit counter) instance share the same F/G stimulus; a monitor checks queued expectations.
module tb_fg_seq_monitor;
    import fg_pkg::*;

    logic       Clock = 1'b0;
    logic       Reset = 1'b0;
    logic       F = 1'b0;
    logic       G = 1'b0;
    logic       Clear = 1'b0;

    logic       done, busy, err;
    logic [2:0] code;
    logic [7:0] txn;
    logic [3:0] errc;
    logic       s_done, s_busy, s_err;
    logic [2:0] s_code;
    logic [1:0] s_txn, s_errc;

    fg_seq_monitor u_dut (
        .Clock(Clock), .Reset(Reset), .F(F), .G(G), .Clear(Clear),
        .Done(done), .Busy(busy), .Err(err), .ErrCode(code),
        .TxnCount(txn), .ErrCount(errc)
    );

    fg_seq_monitor #(.CNT_W(2), .ERR_W(2)) u_small (
        .Clock(Clock), .Reset(Reset), .F(F), .G(G), .Clear(Clear),
        .Done(s_done), .Busy(s_busy), .Err(s_err), .ErrCode(s_code),
        .TxnCount(s_txn), .ErrCount(s_errc)
    );

    always #5 Clock = ~Clock;

    typedef struct {
        int unsigned cyc;
        string       name;
        logic        done, busy, err;
        logic [2:0]  code;
        logic [7:0]  txn;
        logic [3:0]  errc;
        logic [1:0]  stxn, serr;
    } exp_t;

    exp_t        q[$];
    int unsigned cyc = 0;
    int          n_cmp = 0;
    int          n_bad = 0;

    always @(posedge Clock) cyc <= cyc + 1;

    // Monitor: pops every expectation that is due and compares both instances
    always @(negedge Clock) begin
        while (q.size() > 0 && q[0].cyc <= cyc) begin
            exp_t e;
            logic ok;
            e  = q.pop_front();
            ok = (e.cyc == cyc) &&
                 ({done, busy, err, code, txn, errc} === {e.done, e.busy, e.err, e.code, e.txn, e.errc}) &&
                 ({s_done, s_busy, s_err, s_code, s_txn, s_errc} === {e.done, e.busy, e.err, e.code, e.stxn, e.serr});
            n_cmp++;
            if (!ok) begin
                n_bad++;
                $display("FAIL %s cyc=%0d: got done=%b busy=%b err=%b code=%0d txn=%0d errc=%0d small(done=%b busy=%b err=%b code=%0d txn=%0d errc=%0d) want done=%b busy=%b err=%b code=%0d txn=%0d errc=%0d small txn=%0d errc=%0d",
                         e.name, cyc, done, busy, err, code, txn, errc,
                         s_done, s_busy, s_err, s_code, s_txn, s_errc,
                         e.done, e.busy, e.err, e.code, e.txn, e.errc, e.stxn, e.serr);
            end
        end
    end

    task automatic step(input logic f, input logic g, input logic c, input logic r);
        @(negedge Clock);
        F = f; G = g; Clear = c; Reset = r;
    endtask

    task automatic st(input logic f, input logic g);
        step(f, g, 1'b0, 1'b1);
    endtask

    // Expected outputs after the edge that samples the values just driven
    task automatic chk(input string nm, input logic d, input logic b, input logic e,
                       input int c, input int t, input int ec, input int st_, input int se);
        exp_t x;
        x.cyc  = cyc + 1;
        x.name = nm;
        x.done = d; x.busy = b; x.err = e;
        x.code = c[2:0]; x.txn = t[7:0]; x.errc = ec[3:0];
        x.stxn = st_[1:0]; x.serr = se[1:0];
        q.push_back(x);
    endtask

    // Clear from IDLE, play n {F,G} pairs (msb pair first), expect a first-error code
    task automatic run_err(input string nm, input int c, input logic [5:0] seq, input int n);
        step(1'b0, 1'b0, 1'b1, 1'b1);
        chk({nm, "_clr"}, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < n; i++) begin
            logic [1:0] p;
            p = seq[5 - 2*i -: 2];
            st(p[1], p[0]);
        end
        chk(nm, 0, 0, 1, c, 0, 1, 0, 1);
        st(1'b0, 1'b0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset and idle
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        chk("reset", 0, 0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 1);
        chk("idle", 0, 0, 0, 0, 0, 0, 0, 0);

        // Five back-to-back legal transactions at the minimum period
        for (int k = 1; k <= 5; k++) begin
            for (int s = 0; s < int'(SEQ_LEN); s++) begin
                if (s == 0) begin
                    st(1, 0); chk("f_cycle", 0, 1, 0, 0, k-1, 0, (k-1) % 4, 0);
                end else if (s == 1) begin
                    st(0, 1); chk("g_cycle", 0, 1, 0, 0, k-1, 0, (k-1) % 4, 0);
                end else begin
                    st(0, 0); chk("done", 1, 0, 0, 0, k, 0, k % 4, 0);
                end
            end
        end

        // F held too long, stays in RESYNC until 00, then recovers
        st(1, 0); chk("f_first", 0, 1, 0, 0, 5, 0, 1, 0);
        st(1, 0); chk("f_long", 0, 0, 1, 2, 5, 1, 1, 1);
        repeat (3) st(1, 0);
        chk("resync_hold", 0, 0, 1, 2, 5, 1, 1, 1);
        st(0, 0); chk("resync_exit", 0, 0, 1, 2, 5, 1, 1, 1);
        st(1, 0); st(0, 1); st(0, 0);
        chk("txn_after_resync", 1, 0, 1, 2, 6, 1, 2, 1);

        // First error wins
        step(0, 0, 1, 1); chk("clear", 0, 0, 0, 0, 0, 0, 0, 0);
        st(0, 1); chk("g_without_f", 0, 0, 1, 1, 0, 1, 0, 1);
        st(0, 0); st(1, 0); st(0, 1); st(1, 0);
        chk("no_gap_second", 0, 0, 1, 1, 0, 2, 0, 2);
        st(0, 0);

        // Error counter saturation in the narrow instance
        for (int j = 1; j <= 3; j++) begin
            if (j == 2) st(1, 1); else st(0, 1);
            chk("err_sat", 0, 0, 1, 1, 0, 2 + j, 0, (2 + j > 3) ? 3 : 2 + j);
            st(0, 0);
        end

        // Clear coinciding with completion and with an error
        st(1, 0); st(0, 1); st(0, 0);
        chk("pre_clear_txn", 1, 0, 1, 1, 1, 5, 1, 3);
        st(1, 0); st(0, 1);
        step(0, 0, 1, 1); chk("clear_on_done", 1, 0, 0, 0, 0, 0, 0, 0);
        step(0, 1, 1, 1); chk("clear_on_err", 0, 0, 0, 0, 0, 0, 0, 0);
        st(0, 0); chk("resync_after_clr", 0, 0, 0, 0, 0, 0, 0, 0);

        // Reset in S_F, then a stray G
        st(1, 0); chk("pre_reset", 0, 1, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0); chk("mid_reset", 0, 0, 0, 0, 0, 0, 0, 0);
        st(0, 1); chk("stray_g", 0, 0, 1, 1, 0, 1, 0, 1);
        st(0, 0);

        // Each violation code as the first error
        run_err("f_long_code",    2, 6'b10_10_00, 2);
        run_err("g_missing_code", 3, 6'b10_00_00, 2);
        run_err("g_long_code",    4, 6'b10_01_01, 3);
        run_err("no_gap_code",    5, 6'b10_01_10, 3);
        run_err("both_idle_code", 6, 6'b11_00_00, 1);
        run_err("both_sf_code",   6, 6'b10_11_00, 2);
        run_err("both_sg_code",   6, 6'b10_01_11, 3);

        for (int w = 0; w < 10 && q.size() > 0; w++) @(negedge Clock);
        if (q.size() > 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: %0d expectations outstanding, want 0", q.size());
        end
        @(negedge Clock);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
